// File: rtl/handshaking_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : handshaking_pkg                                          |
// | Description : Shared constants and state encoding for the handshaking  |
// |               arbiter and its round-robin picker.                      |
// | Contents    : DEF_NUM_REQ / DEF_DATA_W / DEF_ID_W defaults,            |
// |               state_e (ST_IDLE / ST_FULL).                             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package handshaking_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_ID_W    = 2;

   // Output register occupancy.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } state_e;

endpackage : handshaking_pkg
`default_nettype wire

// File: rtl/handshaking_arbiter_rr_select.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rr_select                                                |
// | Description : Combinational round-robin picker. Searches the request   |
// |               vector starting one past last_grant_i, wrapping modulo   |
// |               NUM_REQ, and reports the first set request.              |
// | Ports       : req_i        [NUM_REQ] request vector                    |
// |               last_grant_i [ID_W]    index granted most recently       |
// |               grant_o      [NUM_REQ] one-hot grant (zero if no req)    |
// |               winner_o     [ID_W]    index of the granted request      |
// |               any_req_o              OR of all requests                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rr_select #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    last_grant_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    winner_o,
   output logic               any_req_o
);

   assign any_req_o = |req_i;

   // Walk offsets 1..NUM_REQ from the pointer; the first hit wins. Offset
   // NUM_REQ lands back on last_grant_i itself, so a lone requester keeps
   // winning every cycle.
   always_comb begin
      logic        found;
      int unsigned idx;
      grant_o  = '0;
      winner_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant_i) + k) % NUM_REQ;
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            winner_o     = ID_W'(idx);
         end
      end
   end

endmodule : rr_select
`default_nettype wire

// File: rtl/handshaking_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : handshaking_arbiter                                      |
// | Description : Round-robin arbiter sharing one valid/ready channel      |
// |               among NUM_REQ masters through a single output register.  |
// | Ports       : clk            clock, rising edge                        |
// |               rst            asynchronous reset, active low            |
// |               req_data_in    packed payloads, req i at [i*DATA_W+:]    |
// |               req_valid_in   per-requester valid                       |
// |               req_ready_out  per-requester ready (one-hot or zero)     |
// |               data_out       registered payload                        |
// |               valid_out      downstream valid                          |
// |               ready_in       downstream ready                          |
// |               grant_id_out   source index of the beat in data_out      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module handshaking_arbiter
   import handshaking_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ID_W    = DEF_ID_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
   input  logic [NUM_REQ-1:0]        req_valid_in,
   output logic [NUM_REQ-1:0]        req_ready_out,
   output logic [DATA_W-1:0]         data_out,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic [ID_W-1:0]           grant_id_out
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ID_W-1:0]     gid_q, gid_d;
   logic [ID_W-1:0]     last_q, last_d;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_winner;
   logic                w_any;
   logic                w_can_load;
   logic                w_load;
   logic [DATA_W-1:0]   w_win_data;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_select (
      .req_i        (req_valid_in),
      .last_grant_i (last_q),
      .grant_o      (w_grant),
      .winner_o     (w_winner),
      .any_req_o    (w_any)
   );

   // The register may be refilled when empty, or when its current beat
   // leaves this same cycle. Gating with rst keeps ready low during reset.
   assign w_can_load    = (state_q == ST_IDLE) || ready_in;
   assign w_load        = rst && w_can_load && w_any;
   assign req_ready_out = w_load ? w_grant : '0;

   // One-hot payload mux.
   always_comb begin
      w_win_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_win_data = req_data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      gid_d   = gid_q;
      last_d  = last_q;
      if (w_load) begin
         // A load wins over a simultaneous drain: the new beat replaces the
         // departing one and valid_out stays high.
         state_d = ST_FULL;
         data_d  = w_win_data;
         gid_d   = w_winner;
         last_d  = w_winner;
      end else if ((state_q == ST_FULL) && ready_in) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         gid_q   <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
      end
   end

   assign valid_out    = (state_q == ST_FULL);
   assign data_out     = data_q;
   assign grant_id_out = gid_q;

endmodule : handshaking_arbiter
`default_nettype wire
